math_expression_master: RTL

Initiator-side sequencer for the math_expression engine. It buffers operand tuples {a,b,c,d} from an upstream valid/ready source and issues each tuple to the engine as a one-cycle start pulse. It then waits for the engine's one-cycle done tick, and returns q, rmd and the reconstructed numerator through a downstream valid/ready port. A watchdog flags engines that never respond.

---
 rtl/math_expression_master_pkg.sv | 17 +
 rtl/math_expression_master_if.sv | 50 +++++
 rtl/math_expression_master_op_fifo.sv | 53 +++++
 rtl/math_expression_master.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/math_expression_master_pkg.sv
// rtl/math_expression_master_pkg.sv - shared types and helpers for the math_expression master
package math_expression_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEFAULT_W = 16;

    // Bits needed for a counter that must reach the timeout value.
    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/math_expression_master_if.sv
// rtl/math_expression_master_if.sv - upstream, engine and downstream signals of the master
interface math_expression_master_if #(parameter int W = 16);

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_a;
    logic signed [W-1:0] in_b;
    logic signed [W-1:0] in_c;
    logic signed [W-1:0] in_d;

    logic                eng_start;
    logic signed [W-1:0] eng_a;
    logic signed [W-1:0] eng_b;
    logic signed [W-1:0] eng_c;
    logic signed [W-1:0] eng_d;
    logic signed [W-1:0] eng_q;
    logic                eng_rmd;
    logic                eng_valid;

    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_q;
    logic                out_rmd;
    logic signed [W-1:0] out_num;
    logic                out_err;

    logic                stray_err;
    logic                busy;

    modport master (
        input  in_valid, in_a, in_b, in_c, in_d,
        output in_ready,
        output eng_start, eng_a, eng_b, eng_c, eng_d,
        input  eng_q, eng_rmd, eng_valid,
        output out_valid, out_q, out_rmd, out_num, out_err,
        input  out_ready,
        output stray_err, busy
    );

    modport slave (
        output in_valid, in_a, in_b, in_c, in_d,
        input  in_ready,
        input  eng_start, eng_a, eng_b, eng_c, eng_d,
        output eng_q, eng_rmd, eng_valid,
        input  out_valid, out_q, out_rmd, out_num, out_err,
        output out_ready,
        input  stray_err, busy
    );

endinterface

// File: rtl/math_expression_master_op_fifo.sv
// rtl/math_expression_master_op_fifo.sv - first-word fall-through operand tuple FIFO
module op_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/math_expression_master.sv
// rtl/math_expression_master.sv - issues buffered operand tuples to the engine and returns results
module math_expression_master
    import math_expression_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    math_expression_master_if.master  bus
);

    localparam int TW = timer_width(TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic            fifo_full;
    logic            fifo_empty;
    logic [4*W-1:0]  fifo_din;
    logic [4*W-1:0]  fifo_dout;
    logic            push;
    logic            issue;
    logic            cap_ok;
    logic            cap_to;
    logic            release_res;

    // Gate in_ready with reset so nothing is offered as accepted while the block is cleared.
    assign bus.in_ready = !fifo_full && !reset;
    assign push         = bus.in_valid && bus.in_ready;
    assign fifo_din     = {bus.in_a, bus.in_b, bus.in_c, bus.in_d};
    assign bus.busy     = (state != IDLE) || !fifo_empty;

    op_fifo #(
        .WIDTH (4*W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (issue),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and one-cycle control strobes; engine response beats the timeout.
    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        cap_ok      = 1'b0;
        cap_to      = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.eng_valid) begin
                    cap_ok    = 1'b1;
                    state_nxt = HOLD;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    cap_to    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    release_res = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Watchdog timer: cleared on issue, counts every cycle spent waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              timer <= '0;
        else if (issue)         timer <= '0;
        else if (state == WAIT) timer <= timer + 1'b1;
    end

    // Engine-side registers: start pulse and operands that stay put until the next issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.eng_start <= 1'b0;
            bus.eng_a     <= '0;
            bus.eng_b     <= '0;
            bus.eng_c     <= '0;
            bus.eng_d     <= '0;
        end else begin
            bus.eng_start <= issue;
            if (issue) {bus.eng_a, bus.eng_b, bus.eng_c, bus.eng_d} <= fifo_dout;
        end
    end

    // Result registers: capture from engine or timeout, hold until downstream accepts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_q     <= '0;
            bus.out_rmd   <= 1'b0;
            bus.out_num   <= '0;
            bus.out_err   <= 1'b0;
        end else if (cap_ok) begin
            bus.out_valid <= 1'b1;
            bus.out_q     <= bus.eng_q;
            bus.out_rmd   <= bus.eng_rmd;
            bus.out_num   <= {bus.eng_q[W-2:0], bus.eng_rmd};
            bus.out_err   <= 1'b0;
        end else if (cap_to) begin
            bus.out_valid <= 1'b1;
            bus.out_q     <= '0;
            bus.out_rmd   <= 1'b0;
            bus.out_num   <= '0;
            bus.out_err   <= 1'b1;
        end else if (release_res) begin
            bus.out_valid <= 1'b0;
            bus.out_err   <= 1'b0;
        end
    end

    // Sticky flag for engine ticks that arrive when no transaction is waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               bus.stray_err <= 1'b0;
        else if (bus.eng_valid && state != WAIT) bus.stray_err <= 1'b1;
    end

endmodule
